// File: rtl/tg_sched.sv
// tg_sched - profile sequencer for a single traffic generator instance.
//
// Holds a small table of test profiles written from the host side. On start it
// walks the table: each entry is loaded onto the generator config outputs, held
// stable with enable low while the generator's input pipeline settles, then the
// generator is enabled and completed packets (tlast handshakes) are counted on
// the monitored stream. Once the profile's packet count is reached, enable
// drops for a drain period before the next entry is loaded. With wrap set, the
// walk loops over the table until aborted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_*                table write port (accepted only while idle)
//   num_profiles, wrap  run setup, sampled when start is accepted
//   start, abort        run control pulses
//   mon_t*              taps of the generator output stream handshake
//   tg_*                generator config, zero-extended; tg_mode[0] is enable
//   busy, done, aborted run status; done/aborted pulse for one cycle at the end
//   cur_profile         table entry currently loaded
//   pkts_sent           packets completed in the current profile
module tg_sched #(
    parameter int DEPTH         = 8,
    parameter int AW            = $clog2(DEPTH),
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_mode,
    input  logic [15:0]   wr_num_packets,
    input  logic [15:0]   wr_num_flits,
    input  logic [7:0]    wr_last_flit_bytes,
    input  logic [15:0]   wr_M,
    input  logic [15:0]   wr_N,
    input  logic [AW:0]   num_profiles,
    input  logic          start,
    input  logic          abort,
    input  logic          wrap,
    input  logic          mon_tvalid,
    input  logic          mon_tready,
    input  logic          mon_tlast,
    output logic [31:0]   tg_mode,
    output logic [31:0]   tg_num_packets,
    output logic [31:0]   tg_num_flits,
    output logic [31:0]   tg_last_flit_bytes,
    output logic [31:0]   tg_M,
    output logic [31:0]   tg_N,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] cur_profile,
    output logic [15:0]   pkts_sent
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    // One shared counter serves both the settle and drain waits; it counts
    // 0..N-1, so it only needs to hold the larger of the two minus one.
    localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    logic [7:0]    tbl_mode           [DEPTH];
    logic [15:0]   tbl_num_packets    [DEPTH];
    logic [15:0]   tbl_num_flits      [DEPTH];
    logic [7:0]    tbl_last_flit_bytes[DEPTH];
    logic [15:0]   tbl_M              [DEPTH];
    logic [15:0]   tbl_N              [DEPTH];

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [AW:0]   np_lat;
    logic          wrap_lat;
    logic          abort_pend;
    logic [CW-1:0] cnt;

    logic          beat;
    logic [15:0]   pkts_next;
    logic          last_entry;

    assign beat       = mon_tvalid & mon_tready & mon_tlast;
    assign pkts_next  = pkts_sent + 16'd1;
    assign last_entry = ({1'b0, idx} == (np_lat - (AW+1)'(1)));

    // Profile table: plain storage, no reset. Writes are blocked while a run
    // is in progress so the entry being executed can never change under it.
    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE) begin
            tbl_mode[wr_addr]            <= wr_mode;
            tbl_num_packets[wr_addr]     <= wr_num_packets;
            tbl_num_flits[wr_addr]       <= wr_num_flits;
            tbl_last_flit_bytes[wr_addr] <= wr_last_flit_bytes;
            tbl_M[wr_addr]               <= wr_M;
            tbl_N[wr_addr]               <= wr_N;
        end
    end

    // Sequencer. Config registers are written only in LOAD; afterwards only
    // tg_mode[0] (the enable) moves. An abort outside IDLE/DRAIN takes priority
    // over everything else and funnels into DRAIN so the generator always gets
    // a full drain period with enable low before the run ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            idx                <= '0;
            np_lat             <= '0;
            wrap_lat           <= 1'b0;
            abort_pend         <= 1'b0;
            cnt                <= '0;
            tg_mode            <= '0;
            tg_num_packets     <= '0;
            tg_num_flits       <= '0;
            tg_last_flit_bytes <= '0;
            tg_M               <= '0;
            tg_N               <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            cur_profile        <= '0;
            pkts_sent          <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort && (state == S_LOAD || state == S_SETTLE ||
                          state == S_RUN  || state == S_NEXT)) begin
                tg_mode[0] <= 1'b0;
                abort_pend <= 1'b1;
                cnt        <= '0;
                state      <= S_DRAIN;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (num_profiles == '0) begin
                                done <= 1'b1;
                            end else begin
                                np_lat     <= num_profiles;
                                wrap_lat   <= wrap;
                                idx        <= '0;
                                abort_pend <= 1'b0;
                                busy       <= 1'b1;
                                state      <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        // Enable and the reserved bit 3 are kept clear in the loaded mode.
                        tg_mode            <= {24'd0, tbl_mode[idx] & 8'hF6};
                        tg_num_packets     <= {16'd0, tbl_num_packets[idx]};
                        tg_num_flits       <= {16'd0, tbl_num_flits[idx]};
                        tg_last_flit_bytes <= {24'd0, tbl_last_flit_bytes[idx]};
                        tg_M               <= {16'd0, tbl_M[idx]};
                        tg_N               <= {16'd0, tbl_N[idx]};
                        cur_profile        <= idx;
                        pkts_sent          <= '0;
                        cnt                <= '0;
                        state <= (tbl_num_packets[idx] == 16'd0) ? S_NEXT : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                            tg_mode[0] <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_RUN: begin
                        if (beat) begin
                            pkts_sent <= pkts_next;
                            if (pkts_next == tg_num_packets[15:0]) begin
                                tg_mode[0] <= 1'b0;
                                cnt        <= '0;
                                state      <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // An abort arriving on the final drain cycle still ends the run.
                        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
                            if (abort_pend || abort) begin
                                abort_pend <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                aborted    <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                state <= S_NEXT;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                            if (abort) begin
                                abort_pend <= 1'b1;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (last_entry) begin
                            if (wrap_lat) begin
                                idx   <= '0;
                                state <= S_LOAD;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_LOAD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tg_sched.sv
// tb_tg_sched - self-checking bench for tg_sched.
//
// Single-profile runs come from a table of profile records; multi-profile,
// abort, wrap, write-while-busy and reset cases are hand-written sequences.
// Expected packet counts for counted beats go through a scoreboard queue.
module tb_tg_sched;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_mode;
    logic [15:0]   wr_num_packets;
    logic [15:0]   wr_num_flits;
    logic [7:0]    wr_last_flit_bytes;
    logic [15:0]   wr_M;
    logic [15:0]   wr_N;
    logic [AW:0]   num_profiles;
    logic          start;
    logic          abort;
    logic          wrap;
    logic          mon_tvalid;
    logic          mon_tready;
    logic          mon_tlast;
    logic [31:0]   tg_mode;
    logic [31:0]   tg_num_packets;
    logic [31:0]   tg_num_flits;
    logic [31:0]   tg_last_flit_bytes;
    logic [31:0]   tg_M;
    logic [31:0]   tg_N;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] cur_profile;
    logic [15:0]   pkts_sent;

    tg_sched #(
        .DEPTH(DEPTH), .AW(AW), .SETTLE_CYCLES(4), .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
        .wr_num_packets(wr_num_packets), .wr_num_flits(wr_num_flits),
        .wr_last_flit_bytes(wr_last_flit_bytes), .wr_M(wr_M), .wr_N(wr_N),
        .num_profiles(num_profiles), .start(start), .abort(abort), .wrap(wrap),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .tg_mode(tg_mode), .tg_num_packets(tg_num_packets), .tg_num_flits(tg_num_flits),
        .tg_last_flit_bytes(tg_last_flit_bytes), .tg_M(tg_M), .tg_N(tg_N),
        .busy(busy), .done(done), .aborted(aborted),
        .cur_profile(cur_profile), .pkts_sent(pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mode;
        logic [15:0] pkts;
        logic [15:0] flits;
        logic [7:0]  lfb;
        logic [15:0] m;
        logic [15:0] n;
        bit          stall;
        logic [31:0] exp_mode_settle;
        logic [31:0] exp_mode_run;
    } vec_t;

    vec_t        vecs[4];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] exp_pkts_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic l);
        mon_tvalid = v;
        mon_tready = r;
        mon_tlast  = l;
    endtask

    task automatic writeEntry(input logic [AW-1:0] a, input logic [7:0] mode, input logic [15:0] pkts,
                              input logic [15:0] flits, input logic [7:0] lfb,
                              input logic [15:0] m, input logic [15:0] n);
        wr_en = 1'b1; wr_addr = a; wr_mode = mode; wr_num_packets = pkts;
        wr_num_flits = flits; wr_last_flit_bytes = lfb; wr_M = m; wr_N = n;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulseStart(input logic [AW:0] np, input logic w);
        start = 1'b1; num_profiles = np; wrap = w;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output bit seen, output logic ab);
        seen = 1'b0;
        ab   = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                ab   = aborted;
            end
        end
        checkOutput("done_within_bound", 32'(seen), 32'd1);
    endtask

    task automatic runVector(input int i);
        vec_t v;
        v = vecs[i];
        applyStimulus(1'b0, 1'b0, 1'b0);
        writeEntry('0, v.mode, v.pkts, v.flits, v.lfb, v.m, v.n);
        pulseStart(4'd1, 1'b0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        tick();
        checkOutput("settle_mode", tg_mode, v.exp_mode_settle);
        checkOutput("cfg_pkts", tg_num_packets, {16'd0, v.pkts});
        checkOutput("cfg_flits", tg_num_flits, {16'd0, v.flits});
        checkOutput("cfg_lfb", tg_last_flit_bytes, {24'd0, v.lfb});
        checkOutput("cfg_M", tg_M, {16'd0, v.m});
        checkOutput("cfg_N", tg_N, {16'd0, v.n});
        checkOutput("cur_profile_load", 32'(cur_profile), 32'd0);
        checkOutput("pkts_cleared", 32'(pkts_sent), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("settle_enable_low", 32'(tg_mode[0]), 32'd0);
        end
        tick();
        checkOutput("run_mode", tg_mode, v.exp_mode_run);
        for (int k = 1; k <= int'(v.pkts); k++) begin
            if (v.stall) begin
                applyStimulus(1'b1, 1'b0, 1'b1);
                tick();
                checkOutput("stall_no_count", 32'(pkts_sent), 32'(k - 1));
                applyStimulus(1'b1, 1'b1, 1'b0);
                tick();
                checkOutput("no_tlast_no_count", 32'(pkts_sent), 32'(k - 1));
            end
            applyStimulus(1'b1, 1'b1, 1'b1);
            exp_pkts_q.push_back(16'(k));
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("pkts_sent", 32'(pkts_sent), 32'(exp_pkts_q.pop_front()));
        end
        checkOutput("enable_drops_with_last", 32'(tg_mode[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("no_done_in_drain", 32'(done), 32'd0);
        end
        checkOutput("cfg_stable_drain", tg_mode, v.exp_mode_settle);
        tick();
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("aborted_clear", 32'(aborted), 32'd0);
        checkOutput("busy_clear", 32'(busy), 32'd0);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic threeProfiles();
        logic [AW-1:0] seq[$];
        logic [AW-1:0] rise_cp[$];
        logic          en_prev;
        bit            seen;
        logic          ab;
        int            beats;
        beats = 0;
        seen  = 1'b0;
        ab    = 1'b0;
        writeEntry(3'd0, 8'h01, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
        writeEntry(3'd1, 8'h01, 16'd0, 16'd1, 8'd1, 16'd1, 16'd1);
        writeEntry(3'd2, 8'h01, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pulseStart(4'd3, 1'b0);
        tick();
        seq.push_back(cur_profile);
        en_prev = tg_mode[0];
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (en_prev) beats++;
            if (tg_mode[0] && !en_prev) rise_cp.push_back(cur_profile);
            if (cur_profile != seq[$]) seq.push_back(cur_profile);
            en_prev = tg_mode[0];
            if (done) begin
                seen = 1'b1;
                ab   = aborted;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("seq_done_seen", 32'(seen), 32'd1);
        checkOutput("seq_not_aborted", 32'(ab), 32'd0);
        checkOutput("seq_profiles_count", 32'(seq.size()), 32'd3);
        for (int k = 0; k < 3 && k < seq.size(); k++)
            checkOutput("seq_profile_order", 32'(seq[k]), 32'(k));
        checkOutput("seq_enable_pulses", 32'(rise_cp.size()), 32'd2);
        if (rise_cp.size() == 2) begin
            checkOutput("seq_enable_prof0", 32'(rise_cp[0]), 32'd0);
            checkOutput("seq_enable_prof2", 32'(rise_cp[1]), 32'd2);
        end
        checkOutput("seq_beats_counted", 32'(beats), 32'd2);
    endtask

    task automatic abortInRun();
        bit found;
        found = 1'b0;
        writeEntry(3'd0, 8'h01, 16'd2, 16'd1, 8'd1, 16'd1, 16'd1);
        writeEntry(3'd1, 8'h01, 16'd3, 16'd1, 8'd1, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pulseStart(4'd2, 1'b1);
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            if (tg_mode[0] && cur_profile == 3'd1) found = 1'b1;
        end
        checkOutput("abort_reach_profile1", 32'(found), 32'd1);
        exp_pkts_q.push_back(16'd1);
        tick();
        checkOutput("abort_pkts_before", 32'(pkts_sent), 32'(exp_pkts_q.pop_front()));
        applyStimulus(1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_enable_low", 32'(tg_mode[0]), 32'd0);
        checkOutput("abort_busy_held", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drain_beat_ignored", 32'(pkts_sent), 32'd1);
        checkOutput("abort_no_early_done", 32'(done), 32'd0);
        tick();
        tick();
        checkOutput("abort_no_done_3", 32'(done), 32'd0);
        tick();
        checkOutput("abort_done", 32'(done), 32'd1);
        checkOutput("abort_flag", 32'(aborted), 32'd1);
        checkOutput("abort_busy_clear", 32'(busy), 32'd0);
        checkOutput("abort_cur_profile", 32'(cur_profile), 32'd1);
    endtask

    task automatic wrapRun();
        logic [AW-1:0] rise_cp[$];
        logic          en_prev;
        bit            any_done;
        bit            seen;
        logic          ab;
        any_done = 1'b0;
        writeEntry(3'd1, 8'h01, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
        writeEntry(3'd0, 8'h01, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pulseStart(4'd2, 1'b1);
        en_prev = tg_mode[0];
        for (int c = 0; c < 90; c++) begin
            tick();
            if (tg_mode[0] && !en_prev) rise_cp.push_back(cur_profile);
            en_prev = tg_mode[0];
            if (done) any_done = 1'b1;
        end
        checkOutput("wrap_no_done", 32'(any_done), 32'd0);
        checkOutput("wrap_enough_profiles", 32'(rise_cp.size() >= 6), 32'd1);
        for (int k = 0; k < 4 && k < rise_cp.size(); k++)
            checkOutput("wrap_alternates", 32'(rise_cp[k]), 32'(k % 2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        waitDone(20, seen, ab);
        checkOutput("wrap_abort_flag", 32'(ab), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeWhileBusy();
        bit   seen;
        logic ab;
        writeEntry(3'd0, 8'h11, 16'd1, 16'd7, 8'd3, 16'd5, 16'd6);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pulseStart(4'd1, 1'b0);
        tick();
        writeEntry(3'd0, 8'h21, 16'd1, 16'd99, 8'd9, 16'd8, 16'd9);
        waitDone(30, seen, ab);
        pulseStart(4'd1, 1'b0);
        tick();
        checkOutput("busy_write_ignored_flits", tg_num_flits, 32'd7);
        checkOutput("busy_write_ignored_mode", tg_mode, 32'h10);
        waitDone(30, seen, ab);
        writeEntry(3'd0, 8'h21, 16'd1, 16'd99, 8'd9, 16'd8, 16'd9);
        pulseStart(4'd1, 1'b0);
        tick();
        checkOutput("idle_write_flits", tg_num_flits, 32'd99);
        checkOutput("idle_write_mode", tg_mode, 32'h20);
        waitDone(30, seen, ab);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pulseStart(4'd0, 1'b0);
        checkOutput("np0_done", 32'(done), 32'd1);
        checkOutput("np0_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("np0_done_clear", 32'(done), 32'd0);
        checkOutput("np0_busy_still", 32'(busy), 32'd0);
    endtask

    initial begin
        bit   seen;
        logic ab;
        vecs[0] = '{8'h05, 16'd3, 16'd2,     8'd8,   16'd10,     16'd20,     1'b0, 32'h04, 32'h05};
        vecs[1] = '{8'hFF, 16'd3, 16'd1,     8'd4,   16'hFFFF,   16'd1,      1'b1, 32'hF6, 32'hF7};
        vecs[2] = '{8'h08, 16'd1, 16'h0100,  8'hFF,  16'd0,      16'hABCD,   1'b0, 32'h00, 32'h01};
        vecs[3] = '{8'h0E, 16'd2, 16'd5,     8'd1,   16'd3,      16'd4,      1'b1, 32'h06, 32'h07};

        wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_num_packets = '0; wr_num_flits = '0;
        wr_last_flit_bytes = '0; wr_M = '0; wr_N = '0; num_profiles = '0;
        start = 1'b0; abort = 1'b0; wrap = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mode", tg_mode, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_pkts", 32'(pkts_sent), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);
        checkOutput("idle_abort_done", 32'(done), 32'd0);

        for (int i = 0; i < 4; i++) runVector(i);

        threeProfiles();
        abortInRun();
        wrapRun();
        writeWhileBusy();

        // Start and abort together while idle: the run starts and completes normally.
        writeEntry(3'd0, 8'h01, 16'd1, 16'd1, 8'd1, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        abort = 1'b1;
        pulseStart(4'd1, 1'b0);
        abort = 1'b0;
        checkOutput("start_beats_abort", 32'(busy), 32'd1);
        waitDone(30, seen, ab);
        checkOutput("start_beats_abort_flag", 32'(ab), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset in the middle of RUN clears enable without waiting for a clock.
        writeEntry(3'd0, 8'h01, 16'd5, 16'd1, 8'd1, 16'd1, 16'd1);
        pulseStart(4'd1, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("pre_reset_enable", 32'(tg_mode[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_enable", 32'(tg_mode[0]), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_cfg", tg_num_packets, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
